// File: rtl/read_write_burst_if.sv
// read_write_burst_if: transaction bus between the burst engine and the protocol FSM.
interface read_write_burst_if #(parameter int DATA_W = 64);
  logic              free;
  logic              bad;
  logic [DATA_W-1:0] data_up_pro;
  logic              send_in;
  logic              input_ready;
  logic [6:0]        addr;
  logic [3:0]        endp;
  logic [DATA_W-1:0] data_down_pro;
  modport master (input free, bad, data_up_pro,
                  output send_in, input_ready, addr, endp, data_down_pro);
  modport slave  (output free, bad, data_up_pro,
                  input send_in, input_ready, addr, endp, data_down_pro);
endinterface

// File: rtl/read_write_burst.sv
// read_write_burst: splits a read/write burst into an address transaction plus per-word data transactions with retry.
module read_write_burst #(
  parameter int         DATA_W    = 64,
  parameter int         ADDR_W    = 16,
  parameter int         MAX_WORDS = 4,
  parameter int         MAX_RETRY = 3,
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] ADDR_ENDP = 4'd4,
  parameter logic [3:0] DATA_ENDP = 4'd8,
  localparam int        LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              tran_ready,
  input  logic              read,
  input  logic [ADDR_W-1:0] mempage,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] data_up_rw,
  output logic              recv_ready,
  output logic              done,
  output logic              cancel,
  output logic              busy,
  read_write_burst_if.master pro
);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  typedef enum logic [2:0] {IDLE, ADDR_ISSUE, ADDR_WAIT, DATA_ISSUE, DATA_WAIT, FINISH} state_t;
  state_t            state;
  logic              rd, held, fail;
  logic [ADDR_W-1:0] page;
  logic [LEN_W-1:0]  len_q, cnt;
  logic [RTY_W-1:0]  rty;
  logic [DATA_W-1:0] hold;
  logic              addr_ph, data_ph;
  assign addr_ph = state == ADDR_ISSUE || state == ADDR_WAIT;
  assign data_ph = state == DATA_ISSUE || state == DATA_WAIT;
  assign busy = state != IDLE;
  // A held word means this is a retry: reissue from the hold register, no new handshake.
  assign wr_ready = state == DATA_ISSUE && !rd && !held;
  assign pro.input_ready = state == ADDR_ISSUE || (state == DATA_ISSUE && (rd || held || wr_valid));
  assign pro.send_in = data_ph && rd;
  assign pro.addr = (addr_ph || data_ph) ? DEV_ADDR : '0;
  assign pro.endp = addr_ph ? ADDR_ENDP : data_ph ? DATA_ENDP : '0;
  assign pro.data_down_pro = addr_ph ? DATA_W'({len_q, page}) :
                             (data_ph && !rd) ? (held ? hold : wr_data) : '0;
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) begin
      state      <= IDLE;
      rd         <= 1'b0;
      held       <= 1'b0;
      fail       <= 1'b0;
      page       <= '0;
      len_q      <= '0;
      cnt        <= '0;
      rty        <= '0;
      hold       <= '0;
      data_up_rw <= '0;
      recv_ready <= 1'b0;
      done       <= 1'b0;
      cancel     <= 1'b0;
    end else begin
      done       <= 1'b0;
      cancel     <= 1'b0;
      recv_ready <= 1'b0;
      case (state)
        IDLE: if (tran_ready) begin
          if (len != '0 && len <= LEN_W'(MAX_WORDS)) begin
            rd    <= read;
            page  <= mempage;
            len_q <= len;
            cnt   <= '0;
            rty   <= '0;
            held  <= 1'b0;
            fail  <= 1'b0;
            state <= ADDR_ISSUE;
          end else begin
            fail  <= 1'b1;
            state <= FINISH;
          end
        end
        ADDR_ISSUE: state <= ADDR_WAIT;
        DATA_ISSUE: if (pro.input_ready) begin
          if (wr_ready) begin
            hold <= wr_data;
            held <= 1'b1;
          end
          state <= DATA_WAIT;
        end
        ADDR_WAIT, DATA_WAIT:
          if (pro.bad) begin
            if (rty == RTY_W'(MAX_RETRY)) begin
              fail  <= 1'b1;
              state <= FINISH;
            end else begin
              rty   <= rty + 1'b1;
              state <= state == ADDR_WAIT ? ADDR_ISSUE : DATA_ISSUE;
            end
          end else if (pro.free) begin
            rty <= '0;
            if (state == ADDR_WAIT) state <= DATA_ISSUE;
            else begin
              cnt        <= cnt + 1'b1;
              held       <= 1'b0;
              data_up_rw <= rd ? pro.data_up_pro : data_up_rw;
              recv_ready <= rd;
              state      <= cnt + 1'b1 == len_q ? FINISH : DATA_ISSUE;
            end
          end
        FINISH: begin
          done   <= 1'b1;
          cancel <= fail;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_read_write_burst.sv
// tb_read_write_burst: randomized bursts against a transaction-level model; scoreboard queues checked by a monitor.
module tb_read_write_burst;
  localparam int MAXW = 4;
  localparam int MAXR = 3;
  logic        clk = 0, rst_L = 0, tran_ready = 0, read = 0, wr_valid = 0;
  logic [15:0] mempage = 0;
  logic [2:0]  len = 0;
  logic [63:0] wr_data = 0, data_up_rw;
  logic        wr_ready, recv_ready, done, cancel, busy;
  read_write_burst_if #(.DATA_W(64)) pro ();
  read_write_burst dut (.clk(clk), .rst_L(rst_L), .tran_ready(tran_ready), .read(read),
    .mempage(mempage), .len(len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .data_up_rw(data_up_rw), .recv_ready(recv_ready), .done(done), .cancel(cancel),
    .busy(busy), .pro(pro));

  typedef struct {bit si; logic [3:0] ep; logic [63:0] pl; bit chk; bit wr;} iss_t;
  typedef struct {bit bad; bit both; logic [63:0] d; int dly;} pln_t;
  iss_t        issue_q[$];
  pln_t        plan_q[$];
  logic [63:0] recv_q[$];
  bit          done_q[$];
  int total = 0, nbad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, hs_cnt = 0;
  int wb[4], wdly[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every DUT-presented event is matched against the head of its queue.
  always @(negedge clk) begin
    iss_t e;
    if (wr_valid && wr_ready) hs_cnt++;
    if (pro.input_ready) begin
      if (issue_q.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        e = issue_q.pop_front();
        chk("issue_send_in", pro.send_in, e.si);
        chk("issue_endp", pro.endp, e.ep);
        chk("issue_addr", pro.addr, 5);
        chk("issue_wr_ready", wr_ready, e.wr);
        if (e.chk) chk("issue_payload", pro.data_down_pro, e.pl);
      end
    end
    if (recv_ready) begin
      if (recv_q.size() == 0) chk("unexpected_recv", 1, 0);
      else chk("recv_data", data_up_rw, recv_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cancel", cancel, done_q.pop_front());
    end
  end

  // Protocol FSM stand-in: answers each issue with the planned free/bad after a delay.
  initial begin
    pln_t pl;
    logic [63:0] snap_d;
    logic [11:0] snap_c;
    pro.free = 0; pro.bad = 0; pro.data_up_pro = 0;
    forever begin
      @(negedge clk);
      while (pro.input_ready) begin
        pl = plan_q.size() != 0 ? plan_q.pop_front() : '{0, 0, 0, 0};
        snap_d = pro.data_down_pro;
        snap_c = {pro.send_in, pro.addr, pro.endp};
        repeat (pl.dly + 1) @(negedge clk);
        if (!rst_L) break;
        chk("hold_payload", pro.data_down_pro, snap_d);
        chk("hold_ctrl", {pro.send_in, pro.addr, pro.endp}, snap_c);
        pro.bad = pl.bad;
        pro.free = !pl.bad || pl.both;
        pro.data_up_pro = pl.d;
        @(negedge clk);
        pro.free = 0; pro.bad = 0;
      end
    end
  end

  task automatic run_burst(input bit r, input logic [15:0] p, input int n, input int ab);
    logic [63:0] words[$];
    logic [63:0] w, d;
    bit ok;
    int c0, start, hs0;
    if (n == 0 || n > MAXW) done_q.push_back(1);
    else begin
      ok = 1;
      for (int a = 0; a <= ab && a <= MAXR; a++) begin
        issue_q.push_back('{0, 4'd4, (64'(n) << 16) | 64'(p), 1, 0});
        plan_q.push_back('{a < ab, $urandom % 2 == 1, rand64(), $urandom_range(0, 2)});
      end
      if (ab > MAXR) ok = 0;
      for (int i = 0; i < n && ok; i++) begin
        w = rand64();
        d = rand64();
        for (int a = 0; a <= wb[i] && a <= MAXR; a++) begin
          issue_q.push_back('{r, 4'd8, r ? 64'd0 : w, !r, !r && a == 0});
          plan_q.push_back('{a < wb[i], $urandom % 2 == 1, a < wb[i] ? rand64() : d, $urandom_range(0, 2)});
        end
        if (!r) words.push_back(w);
        if (wb[i] > MAXR) ok = 0;
        else if (r) recv_q.push_back(d);
      end
      done_q.push_back(!ok);
    end
    start = done_cnt;
    hs0 = hs_cnt;
    @(posedge clk); #1;
    c0 = cyc;
    tran_ready = 1; read = r; mempage = p; len = 3'(n);
    @(posedge clk); #1;
    tran_ready = 0; read = $urandom % 2; mempage = 16'($urandom); len = 3'($urandom);
    for (int i = 0; i < words.size(); i++) begin
      int k;
      repeat (wdly[i]) @(posedge clk);
      #1 wr_valid = 1; wr_data = words[i];
      for (k = 0; k < 200; k++) begin
        @(negedge clk);
        if (wr_ready) break;
      end
      chk("wr_ready_seen", k < 200, 1);
      @(posedge clk); #1;
      wr_valid = 0; wr_data = rand64();
    end
    for (int k = 0; k < 400 && done_cnt == start; k++) @(negedge clk);
    chk("done_seen", done_cnt != start, 1);
    if (n == 0 || n > MAXW) chk("reject_latency", done_cyc - c0, 2);
    chk("wr_handshakes", hs_cnt - hs0, words.size());
    repeat (2) @(negedge clk);
    chk("left_issues", issue_q.size(), 0);
    chk("left_recv", recv_q.size(), 0);
    chk("left_done", done_q.size(), 0);
    issue_q.delete(); plan_q.delete(); recv_q.delete(); done_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    wb = '{0, 0, 0, 0};
    wdly = '{0, 0, 0, 0};
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_input_ready", pro.input_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_payload", pro.data_down_pro, 0);
    rst_L = 1;
    run_burst(1, 16'h1234, 2, 0);
    wdly = '{0, 5, 0, 0};
    run_burst(0, 16'h00a0, 3, 0);
    wdly = '{0, 0, 0, 0};
    wb = '{0, 2, 0, 0};
    run_burst(0, 16'h0bad, 3, 0);
    wb = '{0, 0, 0, 0};
    run_burst(1, 16'h4444, 2, 4);
    run_burst(1, 16'h0001, 0, 0);
    run_burst(0, 16'h0002, MAXW + 1, 0);
    wb = '{0, 4, 0, 0};
    run_burst(0, 16'h0003, 3, 0);
    for (int t = 0; t < 25; t++) begin
      int n;
      n = ($urandom % 8 == 0) ? (($urandom % 2 == 1) ? 0 : MAXW + 1) : $urandom_range(1, MAXW);
      for (int i = 0; i < 4; i++) begin
        wb[i] = ($urandom % 4 == 0) ? $urandom_range(1, 4) : 0;
        wdly[i] = $urandom_range(0, 3);
      end
      run_burst($urandom % 2 == 1, 16'($urandom), n, ($urandom % 6 == 0) ? $urandom_range(1, 4) : 0);
    end
    // Reset while a read data transaction is outstanding.
    start = done_cnt;
    issue_q.push_back('{0, 4'd4, 64'h40007, 1, 0});
    plan_q.push_back('{0, 0, 0, 0});
    issue_q.push_back('{1, 4'd8, 0, 0, 0});
    plan_q.push_back('{0, 0, rand64(), 12});
    @(posedge clk); #1;
    tran_ready = 1; read = 1; mempage = 16'h0007; len = 3'd4;
    @(posedge clk); #1 tran_ready = 0;
    for (int k = 0; k < 50 && issue_q.size() != 0; k++) @(negedge clk);
    chk("rst_issues_seen", issue_q.size(), 0);
    @(posedge clk); #1 rst_L = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cancel", cancel, 0);
    chk("mid_rst_recv", recv_ready, 0);
    chk("mid_rst_input_ready", pro.input_ready, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_ctrl", {pro.send_in, pro.addr, pro.endp}, 0);
    chk("mid_rst_payload", pro.data_down_pro, 0);
    chk("mid_rst_rdata", data_up_rw, 0);
    issue_q.delete(); plan_q.delete(); recv_q.delete(); done_q.delete();
    repeat (20) @(posedge clk); #1 rst_L = 1;
    repeat (10) @(negedge clk);
    chk("rst_no_done", done_cnt - start, 0);
    wb = '{0, 0, 0, 0};
    run_burst(1, 16'h5555, MAXW, 0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
